// File: rtl/cpu_step_controller.sv
`default_nettype none
// ==========================================================================
// cpu_step_controller : slow_clk -> single-cycle CPU enables, with free-run,
// debounced single-step and halt control. Optional macro: STEP_IMMEDIATE_EN.
// Revision: 1.0
// ==========================================================================
module cpu_step_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state_o,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [15:0]      c_db_last = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic             run1_q, run2_q, run1_d, run2_d;
  logic             b1_q, b2_q, b1_d, b2_d;
  logic [15:0]      db_cnt_q, db_cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             prev_btn_db_q, prev_btn_db_d;
  state_t           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic w_tick;
  logic w_press;

  assign w_tick  = s2_q & ~s3_q;
  assign w_press = btn_db_q & ~prev_btn_db_q;

  // Synchronisers and button debounce
  always_comb begin
    s1_d          = slow_clk;
    s2_d          = s1_q;
    s3_d          = s2_q;
    run1_d        = run_sw;
    run2_d        = run1_q;
    b1_d          = step_btn;
    b2_d          = b1_q;
    db_cnt_d      = db_cnt_q;
    btn_db_d      = btn_db_q;
    prev_btn_db_d = btn_db_q;
    if (b2_q == btn_db_q) begin
      db_cnt_d = 16'd0;
    end else if (db_cnt_q == c_db_last) begin
      btn_db_d = b2_q;
      db_cnt_d = 16'd0;
    end else begin
      db_cnt_d = db_cnt_q + 16'd1;
    end
  end

  // Mode FSM; halt always wins and suppresses any coincident pulse
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt)         state_d = HALTED;
        else if (run2_q)  state_d = RUN;
        else if (w_press) state_d = STEP;
      end
      RUN: begin
        if (halt)         state_d = HALTED;
        else if (!run2_q) state_d = IDLE;
        else              cpu_en_d = w_tick;
      end
      STEP: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
`ifdef STEP_IMMEDIATE_EN
          cpu_en_d = 1'b1;
          state_d  = IDLE;
`else
          if (w_tick) begin
            cpu_en_d = 1'b1;
            state_d  = IDLE;
          end
`endif
        end
      end
      HALTED: begin
        // Switch must be dropped before the CPU may restart
        if (!halt && !run2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    running_d     = (state_d == RUN);
    cycle_count_d = cpu_en_d ? (cycle_count_q + c_cnt_one) : cycle_count_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      run1_q        <= 1'b0;
      run2_q        <= 1'b0;
      b1_q          <= 1'b0;
      b2_q          <= 1'b0;
      db_cnt_q      <= 16'd0;
      btn_db_q      <= 1'b0;
      prev_btn_db_q <= 1'b0;
      state_q       <= IDLE;
      cpu_en_q      <= 1'b0;
      running_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      run1_q        <= run1_d;
      run2_q        <= run2_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      prev_btn_db_q <= prev_btn_db_d;
      state_q       <= state_d;
      cpu_en_q      <= cpu_en_d;
      running_q     <= running_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign state_o     = state_q;
  assign running     = running_q;
  assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ==========================================================================
// tb_cpu_step_controller : scenario and random stimulus checked against an
// edge-level behavioural model built from input history. Revision: 1.0
// ==========================================================================
module tb_cpu_step_controller;
  localparam int MAXC = 4096;
  localparam int DB   = 4;
  localparam int PER  = 20;
`ifdef STEP_IMMEDIATE_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_STEP = 2'd2, M_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst, slow_clk, run_sw, step_btn, halt;
  logic        cpu_en, running, en_w, run_w;
  logic [1:0]  state_o, st_w;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  cpu_step_controller #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(32)) dut (
    .clk_in(clk), .rst(rst), .slow_clk(slow_clk), .run_sw(run_sw), .step_btn(step_btn),
    .halt(halt), .cpu_en(cpu_en), .state_o(state_o), .running(running), .cycle_count(cnt32));

  cpu_step_controller #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(4)) dut_w (
    .clk_in(clk), .rst(rst), .slow_clk(slow_clk), .run_sw(run_sw), .step_btn(step_btn),
    .halt(halt), .cpu_en(en_w), .state_o(st_w), .running(run_w), .cycle_count(cnt4));

  // Input history: entry c is the value applied just after edge c
  logic slow_h [0:MAXC-1];
  logic run_h  [0:MAXC-1];
  logic btn_h  [0:MAXC-1];
  logic halt_h [0:MAXC-1];
  int   cyc, valid_from, slow_ph, last_rise, errors, checks;

  logic        m_en, m_db, m_db_prev;
  logic [1:0]  m_state;
  logic [31:0] m_cnt;

  function automatic logic gs(input int i);
    return (i >= valid_from && i >= 0 && i < MAXC) ? slow_h[i] : 1'b0;
  endfunction
  function automatic logic gr(input int i);
    return (i >= valid_from && i >= 0 && i < MAXC) ? run_h[i] : 1'b0;
  endfunction
  function automatic logic gb(input int i);
    return (i >= valid_from && i >= 0 && i < MAXC) ? btn_h[i] : 1'b0;
  endfunction

  task automatic model_clear();
    m_en = 1'b0; m_db = 1'b0; m_db_prev = 1'b0; m_state = M_IDLE; m_cnt = 32'd0;
  endtask

  // Controller behaviour at edge e: inputs reach the decision logic 3 edges
  // after being applied (halt 1 edge); the button level is accepted once
  // DB consecutive samples disagree with the accepted level.
  task automatic model_edge(input int e);
    logic tick, run, hlt, press, en_n, flip;
    logic [1:0] st_n;
    tick  = gs(e - 3) & ~gs(e - 4);
    run   = gr(e - 3);
    hlt   = (e >= 1 && e - 1 < MAXC) ? halt_h[e - 1] : 1'b0;
    press = m_db & ~m_db_prev;
    flip  = 1'b1;
    for (int k = 3; k < 3 + DB; k++) if (gb(e - k) == m_db) flip = 1'b0;
    en_n = 1'b0;
    st_n = m_state;
    case (m_state)
      M_IDLE: if (hlt) st_n = M_HALT; else if (run) st_n = M_RUN; else if (press) st_n = M_STEP;
      M_RUN:  if (hlt) st_n = M_HALT; else if (!run) st_n = M_IDLE; else en_n = tick;
      M_STEP: if (hlt) st_n = M_HALT; else if (IMM || tick) begin en_n = 1'b1; st_n = M_IDLE; end
      default: if (!hlt && !run) st_n = M_IDLE;
    endcase
    m_db_prev = m_db;
    m_db      = flip ? ~m_db : m_db;
    m_state   = st_n;
    m_en      = en_n;
    m_cnt     = m_cnt + {31'd0, en_n};
  endtask

  // Advance one clock; returns 1 time unit after the edge
  task automatic cycle();
    if (cyc < MAXC) begin
      slow_h[cyc] = slow_clk; run_h[cyc] = run_sw; btn_h[cyc] = step_btn; halt_h[cyc] = halt;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) model_edge(cyc);
    slow_ph = (slow_ph + 1) % PER;
    if (!slow_clk && slow_ph < PER / 2) last_rise = cyc;
    slow_clk = (slow_ph < PER / 2);
  endtask

  task automatic test_reset();
    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0;
    model_clear();
    repeat (3) cycle();
    checks++;
    if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !== '0) begin
      errors++;
      $display("FAIL reset_hold: en=%b state=%0d run=%b cnt=%0d, required all zero", cpu_en, state_o, running, cnt32);
    end
    rst = 1'b0; valid_from = cyc;
    repeat (25) begin
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL reset_release cyc=%0d: en=%b state=%0d cnt=%0d cnt4=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, cnt4, m_en, m_state, m_cnt);
      end
    end
    checks++;
    if (state_o !== M_IDLE || cnt32 !== 32'd0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d cnt=%0d, required 0 and 0", state_o, cnt32);
    end
  endtask

  task automatic test_free_run();
    int pulses;
    logic [31:0] base;
    run_sw = 1'b1;
    for (int i = 0; i < 10 && running !== 1'b1; i++) cycle();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: running=%b, required 1", running);
    end
    base = m_cnt; pulses = 0;
    repeat (10 * PER) begin
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL free_run cyc=%0d: en=%b state=%0d cnt=%0d cnt4=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, cnt4, m_en, m_state, m_cnt);
      end
      if (cpu_en === 1'b1) begin
        pulses++;
        checks++;
        if (cyc - last_rise != 3) begin
          errors++;
          $display("FAIL pulse_latency: %0d edges after rise, required 3", cyc - last_rise);
        end
      end
    end
    checks++;
    if (pulses != 10 || cnt32 !== base + 32'd10 || running !== 1'b1) begin
      errors++;
      $display("FAIL free_run_count: pulses=%0d cnt=%0d running=%b, required 10, %0d, 1",
               pulses, cnt32, running, base + 32'd10);
    end
  endtask

  task automatic test_step_bounce();
    int pulses;
    bit saw_step;
    logic [31:0] base;
    run_sw = 1'b0; halt = 1'b0; step_btn = 1'b0;
    repeat (8 + $urandom_range(0, PER - 1)) cycle();
    checks++;
    if (state_o !== M_IDLE) begin
      errors++;
      $display("FAIL step_idle: state=%0d, required 0", state_o);
    end
    base = m_cnt; pulses = 0; saw_step = 1'b0;
    for (int i = 0; i < 100; i++) begin
      // 1,0,1 bounce then held high for 8 cycles, then released; later a 2-cycle glitch
      step_btn = (i == 1) ? 1'b0 : ((i <= 10) || (i >= 60 && i < 62));
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL step cyc=%0d: en=%b state=%0d cnt=%0d cnt4=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, cnt4, m_en, m_state, m_cnt);
      end
      if (cpu_en === 1'b1) pulses++;
      if (state_o === M_STEP) saw_step = 1'b1;
      if (i == 59) begin
        checks++;
        if (pulses != 1 || cnt32 !== base + 32'd1 || !saw_step || state_o !== M_IDLE) begin
          errors++;
          $display("FAIL step_single: pulses=%0d cnt=%0d saw_step=%b state=%0d, required 1, %0d, 1, 0",
                   pulses, cnt32, saw_step, state_o, base + 32'd1);
        end
      end
    end
    checks++;
    if (pulses != 1 || cnt32 !== base + 32'd1) begin
      errors++;
      $display("FAIL step_glitch: pulses=%0d cnt=%0d, required 1 and %0d", pulses, cnt32, base + 32'd1);
    end
  endtask

  task automatic test_halt();
    run_sw = 1'b0; halt = 1'b0; step_btn = 1'b0;
    repeat (6) cycle();
    run_sw = 1'b1;
    for (int i = 0; i < 10 && running !== 1'b1; i++) cycle();
    for (int i = 0; i < PER + 2 && last_rise != cyc; i++) cycle();
    checks++;
    if (running !== 1'b1 || last_rise != cyc) begin
      errors++;
      $display("FAIL halt_setup: running=%b rise_found=%b, required 1 and 1", running, last_rise == cyc);
    end
    repeat (2) cycle();
    halt = 1'b1;
    cycle();
    checks++;
    if (cpu_en !== 1'b0 || state_o !== M_HALT || m_en !== 1'b0 || m_state !== M_HALT) begin
      errors++;
      $display("FAIL halt_coincident: en=%b state=%0d, required 0 and 3", cpu_en, state_o);
    end
    halt = 1'b0;
    repeat (30) begin
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL halt_hold cyc=%0d: en=%b state=%0d cnt=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, m_en, m_state, m_cnt);
      end
    end
    checks++;
    if (state_o !== M_HALT) begin
      errors++;
      $display("FAIL halt_sticky: state=%0d, required 3", state_o);
    end
    run_sw = 1'b0;
    repeat (6) cycle();
    checks++;
    if (state_o !== M_IDLE) begin
      errors++;
      $display("FAIL halt_exit: state=%0d, required 0", state_o);
    end
  endtask

  task automatic test_wrap();
    bit wrapped, after;
    wrapped = 1'b0; after = 1'b0;
    run_sw = 1'b1; halt = 1'b0;
    repeat (21 * PER) begin
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL wrap cyc=%0d: en=%b state=%0d cnt=%0d cnt4=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, cnt4, m_en, m_state, m_cnt);
      end
      if (m_en && wrapped && !after) begin
        after = 1'b1;
        checks++;
        if (cnt4 !== 4'd1) begin
          errors++;
          $display("FAIL wrap_next: cnt4=%0d, required 1", cnt4);
        end
      end
      if (m_en && m_cnt[3:0] == 4'd0 && !wrapped) begin
        wrapped = 1'b1;
        checks++;
        if (cnt4 !== 4'd0 || cnt32 !== m_cnt) begin
          errors++;
          $display("FAIL wrap_zero: cnt4=%0d cnt=%0d, required 0 and %0d", cnt4, cnt32, m_cnt);
        end
      end
    end
    checks++;
    if (!wrapped || !after) begin
      errors++;
      $display("FAIL wrap_seen: wrapped=%b next=%b, required 1 and 1", wrapped, after);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0; run_sw = 1'b0; halt = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 149) == 0) run_sw = ~run_sw;
      if (halt) begin
        if ($urandom_range(0, 7) == 0) halt = 1'b0;
      end else if ($urandom_range(0, 199) == 0) halt = 1'b1;
      if (hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end
      hold--;
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL random cyc=%0d: en=%b state=%0d cnt=%0d cnt4=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, cnt4, m_en, m_state, m_cnt);
      end
    end
  endtask

  task automatic test_reset_midpulse();
    bit got;
    got = 1'b0;
    run_sw = 1'b0; halt = 1'b0; step_btn = 1'b0;
    repeat (8) cycle();
    run_sw = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = (cpu_en === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midpulse_wait: no pulse within 40 cycles, required one");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !== '0) begin
      errors++;
      $display("FAIL reset_async: en=%b state=%0d run=%b cnt=%0d cnt4=%0d, required all zero",
               cpu_en, state_o, running, cnt32, cnt4);
    end
    model_clear();
    run_sw = 1'b0;
    repeat (3) cycle();
    rst = 1'b0; valid_from = cyc;
    repeat (40) begin
      cycle();
      checks++;
      if ({cpu_en, state_o, running, cnt32, en_w, st_w, run_w, cnt4} !==
          {m_en, m_state, m_state == M_RUN, m_cnt, m_en, m_state, m_state == M_RUN, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: en=%b state=%0d cnt=%0d, required en=%b state=%0d cnt=%0d",
                 cyc, cpu_en, state_o, cnt32, m_en, m_state, m_cnt);
      end
    end
    checks++;
    if (state_o !== M_IDLE || cnt32 !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_quiet: state=%0d cnt=%0d, required 0 and 0", state_o, cnt32);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; valid_from = 0; last_rise = -100;
    slow_ph  = $urandom_range(0, PER - 1);
    slow_clk = (slow_ph < PER / 2);
    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0;
    model_clear();
    test_reset();
    test_free_run();
    test_step_bounce();
    test_halt();
    test_wrap();
    test_random();
    test_reset_midpulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
